hand_dealer: RTL

- Upstream stage of the card 7-segment decoders: deals cards, holds the three-card hand and drives one 4-bit card code per display.
- Free-running 1..CARD_MAX counter acts as the "shuffled deck". Each deal request captures the counter into the next empty slot.
- Also keeps the running Baccarat score (sum mod 10). Empty slots output 0, which the decoders show as blank.

---
 rtl/hand_dealer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hand_dealer.sv
//==============================================================================
// Module      : hand_dealer
// Description : Deals up to three cards from a free-running 1..CARD_MAX counter
//               and keeps the running Baccarat score (sum of points mod 10).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hand_dealer #(
    parameter int CARD_MAX = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       clear,
    output logic [3:0] card1,
    output logic [3:0] card2,
    output logic [3:0] card3,
    output logic [3:0] score,
    output logic [1:0] num_cards,
    output logic       hand_full,
    output logic       deal_ack
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(CARD_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       req_d;
    logic       deal_evt;
    logic [3:0] pts;
    logic [4:0] sum;
    logic [4:0] sum_adj;
    logic [3:0] score_sum;
    logic [3:0] card1_nxt;
    logic [3:0] card2_nxt;
    logic [3:0] card3_nxt;
    logic [3:0] score_nxt;
    logic       ack_nxt;

    // req_d resets high so a key held through reset release is not a deal
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            cnt      <= 4'd1;
            req_d    <= 1'b1;
            card1    <= 4'd0;
            card2    <= 4'd0;
            card3    <= 4'd0;
            score    <= 4'd0;
            deal_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            req_d    <= deal_req;
            card1    <= card1_nxt;
            card2    <= card2_nxt;
            card3    <= card3_nxt;
            score    <= score_nxt;
            deal_ack <= ack_nxt;
        end
    end

    always_comb begin
        cnt_nxt   = (cnt == CNT_MAX) ? 4'd1 : cnt + 4'd1;
        deal_evt  = deal_req & ~req_d;
        // Face cards and tens are worth zero; sum of two digits never exceeds 18
        pts       = (cnt <= 4'd9) ? cnt : 4'd0;
        sum       = {1'b0, score} + {1'b0, pts};
        sum_adj   = sum - 5'd10;
        score_sum = (sum >= 5'd10) ? sum_adj[3:0] : sum[3:0];

        state_nxt = state;
        card1_nxt = card1;
        card2_nxt = card2;
        card3_nxt = card3;
        score_nxt = score;
        ack_nxt   = 1'b0;

        if (clear) begin
            state_nxt = EMPTY;
            card1_nxt = 4'd0;
            card2_nxt = 4'd0;
            card3_nxt = 4'd0;
            score_nxt = 4'd0;
        end else if (deal_evt) begin
            case (state)
                EMPTY: begin
                    card1_nxt = cnt;
                    state_nxt = ONE;
                end
                ONE: begin
                    card2_nxt = cnt;
                    state_nxt = TWO;
                end
                TWO: begin
                    card3_nxt = cnt;
                    state_nxt = FULL;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
            if (state != FULL) begin
                score_nxt = score_sum;
                ack_nxt   = 1'b1;
            end
        end
    end

    assign num_cards = state;
    assign hand_full = (state == FULL);

endmodule

`default_nettype wire
